// File: rtl/signed_seq_mult_n.sv
// signed_seq_mult_n: shift-add signed WIDTHxWIDTH multiplier, one step per clock; define SEQ_MULT_EARLY_TERM_EN to stop once remaining multiplier bits are zero
module signed_seq_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 sign
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mag_a, abs_a, abs_b, mag_a_nxt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [CW-1:0] cnt, cnt_nxt;
  logic neg;
  always_comb begin
    abs_a = multiplier[WIDTH-1] ? -multiplier : multiplier;
    abs_b = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
    mag_a_nxt = mag_a >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    cnt_nxt = (mag_a_nxt == '0) ? '0 : cnt - CW'(1);
`else
    cnt_nxt = cnt - CW'(1);
`endif
  end
  // cnt counts remaining steps; cnt==0 in RUN is the finalise cycle that signs the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      product <= '0;
      sign    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
      mag_a   <= '0;
      acc     <= '0;
      mcand   <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ready && start) begin
        state   <= RUN;
        busy    <= 1'b1;
        ready   <= 1'b0;
        mag_a   <= abs_a;
        mcand   <= {{WIDTH{1'b0}}, abs_b};
        acc     <= '0;
        cnt     <= CW'(WIDTH);
        neg     <= multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
        product <= '0;
        sign    <= 1'b0;
      end else if (state == RUN && cnt != '0) begin
        if (mag_a[0]) acc <= acc + mcand;
        mag_a <= mag_a_nxt;
        mcand <= mcand << 1;
        cnt   <= cnt_nxt;
      end else if (state == RUN) begin
        state   <= DONE;
        busy    <= 1'b0;
        ready   <= 1'b1;
        done    <= 1'b1;
        product <= neg ? -acc : acc;
        sign    <= neg & (|acc);
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
